// File: rtl/xgmii_rx_monitor.sv
// rtl/xgmii_rx_monitor.sv - XGMII receive frame monitor with length/control/sequence checking
//
// Purpose: watches a 64-bit XGMII receive stream, delimits frames between
// start (/S/ + preamble + SFD) and terminate (/T/), measures the frame length
// (DA through FCS), checks control-character integrity, and tracks a 32-bit
// big-endian sequence number carried in frame bytes 14..17.
//
// Ports:
//   clk_156        - 156.25 MHz clock, the only clock
//   sys_rst_n      - asynchronous active-low reset
//   xgmii_rxd      - receive data, lane k = bits 8k+7:8k, lane 0 first on wire
//   xgmii_rxc      - per-lane control flags
//   cnt_clr        - synchronous clear of counters and sequence tracking
//   rx_frame_valid - one-cycle pulse per completed frame
//   rx_frame_good  - frame had neither a control nor a length error
//   rx_frame_len   - byte length of the last completed frame
//   good_cnt, len_err_cnt, ctl_err_cnt, seq_err_cnt - saturating event counters

module xgmii_rx_monitor #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk_156,
    input  logic        sys_rst_n,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    input  logic        cnt_clr,
    output logic        rx_frame_valid,
    output logic        rx_frame_good,
    output logic [15:0] rx_frame_len,
    output logic [31:0] good_cnt,
    output logic [31:0] len_err_cnt,
    output logic [31:0] ctl_err_cnt,
    output logic [31:0] seq_err_cnt
);

    localparam logic [63:0] START_WORD = 64'hD5555555_555555FB;
    localparam logic [7:0]  CH_START   = 8'hFB;
    localparam logic [7:0]  CH_TERM    = 8'hFD;
    localparam logic [7:0]  CH_ERROR   = 8'hFE;
    localparam logic [15:0] MIN_L      = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L      = 16'(MAX_LEN);
    localparam logic [15:0] OVF_LEN    = 16'(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] byte_cnt_q;
    logic [31:0] seq_q;
    logic [31:0] exp_seq_q;
    logic        exp_vld_q;
    logic        valid_q;
    logic        good_q;
    logic [15:0] len_q;
    logic [31:0] good_cnt_q;
    logic [31:0] len_err_cnt_q;
    logic [31:0] ctl_err_cnt_q;
    logic [31:0] seq_err_cnt_q;

    // Word decode
    logic        is_start;
    logic        any_fb;
    logic        any_fd;
    logic        any_fe;
    logic        stray_fb;
    logic [2:0]  low_lane;
    logic [7:0]  low_byte;
    logic        term_ok;
    logic [15:0] cnt_plus8;
    logic [15:0] term_len;
    logic        len_bad;
    logic        overflow;

    always_comb begin
        is_start = (xgmii_rxc == 8'h01) && (xgmii_rxd == START_WORD);
        any_fb   = 1'b0;
        any_fd   = 1'b0;
        any_fe   = 1'b0;
        low_lane = 3'd0;
        // Walk downward so the lowest control lane is the one left in low_lane.
        for (int k = 7; k >= 0; k--) begin
            if (xgmii_rxc[k]) begin
                low_lane = 3'(k);
                if (xgmii_rxd[8*k +: 8] == CH_START) any_fb = 1'b1;
                if (xgmii_rxd[8*k +: 8] == CH_TERM)  any_fd = 1'b1;
                if (xgmii_rxd[8*k +: 8] == CH_ERROR) any_fe = 1'b1;
            end
        end
        low_byte  = xgmii_rxd[{low_lane, 3'b000} +: 8];
        term_ok   = (xgmii_rxc != 8'h00) && (low_byte == CH_TERM) && !any_fe;
        stray_fb  = any_fb && !is_start;
        cnt_plus8 = byte_cnt_q + 16'd8;
        // Lanes below the lowest control lane are data bytes of the frame.
        term_len  = byte_cnt_q + {13'd0, low_lane};
        len_bad   = (term_len < MIN_L) || (term_len > MAX_L);
        overflow  = cnt_plus8 > MAX_L;
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            byte_cnt_q    <= 16'd0;
            seq_q         <= 32'd0;
            exp_seq_q     <= 32'd0;
            exp_vld_q     <= 1'b0;
            valid_q       <= 1'b0;
            good_q        <= 1'b0;
            len_q         <= 16'd0;
            good_cnt_q    <= 32'd0;
            len_err_cnt_q <= 32'd0;
            ctl_err_cnt_q <= 32'd0;
            seq_err_cnt_q <= 32'd0;
        end else begin
            valid_q <= 1'b0;
            if (cnt_clr) begin
                // Clear wins over anything this word would have reported.
                state_q       <= IDLE;
                byte_cnt_q    <= 16'd0;
                exp_vld_q     <= 1'b0;
                good_cnt_q    <= 32'd0;
                len_err_cnt_q <= 32'd0;
                ctl_err_cnt_q <= 32'd0;
                seq_err_cnt_q <= 32'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (is_start) begin
                            state_q    <= DATA;
                            byte_cnt_q <= 16'd0;
                        end else if (stray_fb) begin
                            ctl_err_cnt_q <= sat_inc(ctl_err_cnt_q);
                        end
                    end
                    DATA: begin
                        if (is_start) begin
                            // Abort the running frame and open a new one at once.
                            valid_q       <= 1'b1;
                            good_q        <= 1'b0;
                            len_q         <= byte_cnt_q;
                            ctl_err_cnt_q <= sat_inc(ctl_err_cnt_q);
                            byte_cnt_q    <= 16'd0;
                        end else if (xgmii_rxc == 8'h00) begin
                            if (overflow) begin
                                valid_q       <= 1'b1;
                                good_q        <= 1'b0;
                                len_q         <= OVF_LEN;
                                len_err_cnt_q <= sat_inc(len_err_cnt_q);
                                state_q       <= DROP;
                            end else begin
                                byte_cnt_q <= cnt_plus8;
                                // Sequence number spans frame bytes 14..17.
                                if (byte_cnt_q == 16'd8)
                                    seq_q[31:16] <= {xgmii_rxd[55:48], xgmii_rxd[63:56]};
                                if (byte_cnt_q == 16'd16)
                                    seq_q[15:0]  <= {xgmii_rxd[7:0], xgmii_rxd[15:8]};
                            end
                        end else if (term_ok) begin
                            valid_q <= 1'b1;
                            good_q  <= !len_bad;
                            len_q   <= term_len;
                            state_q <= IDLE;
                            if (len_bad) begin
                                len_err_cnt_q <= sat_inc(len_err_cnt_q);
                            end else begin
                                good_cnt_q <= sat_inc(good_cnt_q);
                                if (exp_vld_q && (seq_q != exp_seq_q))
                                    seq_err_cnt_q <= sat_inc(seq_err_cnt_q);
                                exp_seq_q <= seq_q + 32'd1;
                                exp_vld_q <= 1'b1;
                            end
                        end else begin
                            // /E/, idle, or any control byte ahead of /T/.
                            valid_q       <= 1'b1;
                            good_q        <= 1'b0;
                            len_q         <= term_len;
                            ctl_err_cnt_q <= sat_inc(ctl_err_cnt_q);
                            state_q       <= IDLE;
                        end
                    end
                    DROP: begin
                        if (is_start) begin
                            state_q    <= DATA;
                            byte_cnt_q <= 16'd0;
                        end else if (any_fd) begin
                            state_q <= IDLE;
                        end else if (stray_fb) begin
                            ctl_err_cnt_q <= sat_inc(ctl_err_cnt_q);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rx_frame_valid = valid_q;
    assign rx_frame_good  = good_q;
    assign rx_frame_len   = len_q;
    assign good_cnt       = good_cnt_q;
    assign len_err_cnt    = len_err_cnt_q;
    assign ctl_err_cnt    = ctl_err_cnt_q;
    assign seq_err_cnt    = seq_err_cnt_q;

endmodule

// File: tb/tb_xgmii_rx_monitor.sv
// tb/tb_xgmii_rx_monitor.sv - self-checking bench for xgmii_rx_monitor

module tb_xgmii_rx_monitor;

    localparam logic [63:0] START_W = 64'hD5555555_555555FB;
    localparam logic [63:0] IDLE_W  = 64'h07070707_07070707;

    logic        clk_156 = 1'b0;
    logic        sys_rst_n;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic        cnt_clr;
    logic        rx_frame_valid;
    logic        rx_frame_good;
    logic [15:0] rx_frame_len;
    logic [31:0] good_cnt;
    logic [31:0] len_err_cnt;
    logic [31:0] ctl_err_cnt;
    logic [31:0] seq_err_cnt;

    always #5 clk_156 = ~clk_156;

    xgmii_rx_monitor #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk_156        (clk_156),
        .sys_rst_n      (sys_rst_n),
        .xgmii_rxd      (xgmii_rxd),
        .xgmii_rxc      (xgmii_rxc),
        .cnt_clr        (cnt_clr),
        .rx_frame_valid (rx_frame_valid),
        .rx_frame_good  (rx_frame_good),
        .rx_frame_len   (rx_frame_len),
        .good_cnt       (good_cnt),
        .len_err_cnt    (len_err_cnt),
        .ctl_err_cnt    (ctl_err_cnt),
        .seq_err_cnt    (seq_err_cnt)
    );

    typedef struct {
        logic [63:0] rxd;
        logic [7:0]  rxc;
        logic        clr;
        logic        exp_valid;
        logic        exp_good;
        logic        chk_len;
        logic [15:0] exp_len;
    } vec_t;

    vec_t        tbl[$];
    int          checks = 0;
    int          failures = 0;
    int          pulses = 0;
    int          pulse_word;
    logic [15:0] last_len;
    logic        last_good;

    function automatic logic [63:0] data_word(input int w, input logic [31:0] seq);
        logic [63:0] d;
        for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'((w * 8 + j) & 255);
        if (w == 1) begin d[55:48] = seq[31:24]; d[63:56] = seq[23:16]; end
        if (w == 2) begin d[7:0]   = seq[15:8];  d[15:8]  = seq[7:0];   end
        return d;
    endfunction

    function automatic logic [63:0] term_word(input int k);
        logic [63:0] d;
        for (int j = 0; j < 8; j++)
            d[8*j +: 8] = (j < k) ? 8'hAA : ((j == k) ? 8'hFD : 8'h07);
        return d;
    endfunction

    function automatic logic [7:0] term_ctl(input int k);
        logic [7:0] m;
        m = 8'hFF;
        return m << k;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] g, input logic [31:0] l,
                           input logic [31:0] c, input logic [31:0] s);
        chk({tag, "_good_cnt"},    good_cnt,    g);
        chk({tag, "_len_err_cnt"}, len_err_cnt, l);
        chk({tag, "_ctl_err_cnt"}, ctl_err_cnt, c);
        chk({tag, "_seq_err_cnt"}, seq_err_cnt, s);
    endtask

    task automatic send(input logic [63:0] rxd, input logic [7:0] rxc, input logic clr);
        @(negedge clk_156);
        xgmii_rxd = rxd;
        xgmii_rxc = rxc;
        cnt_clr   = clr;
        @(posedge clk_156);
        #1;
        if (rx_frame_valid) begin
            pulses++;
            last_len  = rx_frame_len;
            last_good = rx_frame_good;
        end
    endtask

    task automatic push(input logic [63:0] rxd, input logic [7:0] rxc, input logic clr,
                        input logic ev, input logic eg, input logic cl, input logic [15:0] el);
        vec_t v;
        v.rxd = rxd; v.rxc = rxc; v.clr = clr;
        v.exp_valid = ev; v.exp_good = eg; v.chk_len = cl; v.exp_len = el;
        tbl.push_back(v);
    endtask

    task automatic add_frame(input logic [31:0] seq, input int ndata, input int lane,
                             input bit with_start, input logic eg, input logic [15:0] el);
        if (with_start) push(START_W, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int w = 0; w < ndata; w++) push(data_word(w, seq), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        push(term_word(lane), term_ctl(lane), 1'b0, 1'b1, eg, 1'b1, el);
        push(IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            send(tbl[i].rxd, tbl[i].rxc, tbl[i].clr);
            chk($sformatf("%s_v%0d_valid", tag, i), rx_frame_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                chk($sformatf("%s_v%0d_good", tag, i), rx_frame_good, tbl[i].exp_good);
                if (tbl[i].chk_len)
                    chk($sformatf("%s_v%0d_len", tag, i), rx_frame_len, tbl[i].exp_len);
            end
        end
        tbl.delete();
    endtask

    task automatic send_frame(input logic [31:0] seq, input int ndata, input int lane, input logic clr_on_term);
        send(START_W, 8'h01, 1'b0);
        for (int w = 0; w < ndata; w++) send(data_word(w, seq), 8'h00, 1'b0);
        send(term_word(lane), term_ctl(lane), clr_on_term);
        send(IDLE_W, 8'hFF, 1'b0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        xgmii_rxd = IDLE_W;
        xgmii_rxc = 8'hFF;
        cnt_clr   = 1'b0;
        repeat (3) @(posedge clk_156);
        #1;
        chk("rst_valid", rx_frame_valid, 0);
        chk("rst_good",  rx_frame_good,  0);
        chk("rst_len",   rx_frame_len,   0);
        chk_cnt("rst", 0, 0, 0, 0);
        @(negedge clk_156);
        sys_rst_n = 1'b1;

        // Short frame, sequence run 5/6/8, /E/ inside a frame.
        add_frame(32'h11, 7, 4, 1'b1, 1'b0, 16'd60);
        add_frame(32'd5, 8, 0, 1'b1, 1'b1, 16'd64);
        add_frame(32'd6, 8, 0, 1'b1, 1'b1, 16'd64);
        add_frame(32'd8, 8, 0, 1'b1, 1'b1, 16'd64);
        push(START_W, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int w = 0; w < 3; w++) push(data_word(w, 32'd0), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        push({data_word(3, 32'd0)[63:32], 8'hFE, data_word(3, 32'd0)[23:0]}, 8'h08,
             1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int w = 4; w < 8; w++) push(data_word(w, 32'd0), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        push(term_word(0), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        push(IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        run_table("t1");
        chk_cnt("t1", 3, 1, 1, 1);

        send(IDLE_W, 8'hFF, 1'b1);
        chk("clr_valid", rx_frame_valid, 0);
        chk_cnt("clr", 0, 0, 0, 0);

        // Sequence wrap, start inside a frame, stray /S/, length boundaries.
        add_frame(32'hFFFF_FFFF, 8, 0, 1'b1, 1'b1, 16'd64);
        add_frame(32'h0000_0000, 8, 0, 1'b1, 1'b1, 16'd64);
        push(START_W, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        push(data_word(0, 32'd0), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        push(data_word(1, 32'd0), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        push(START_W, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        add_frame(32'd1, 8, 0, 1'b0, 1'b1, 16'd64);
        push(64'h07070707_070707FB, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        push(IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        add_frame(32'd2, 8, 7, 1'b1, 1'b1, 16'd71);
        add_frame(32'd3, 189, 6, 1'b1, 1'b1, 16'd1518);
        add_frame(32'd99, 189, 7, 1'b1, 1'b0, 16'd1519);
        add_frame(32'd99, 7, 7, 1'b1, 1'b0, 16'd63);
        run_table("t2");
        chk_cnt("t2", 5, 2, 2, 0);

        // Oversize frame: one pulse when the count reaches 1520, then silence until /T/.
        pulses = 0;
        pulse_word = -1;
        send(START_W, 8'h01, 1'b0);
        for (int w = 0; w < 200; w++) begin
            send(data_word(w, 32'd4), 8'h00, 1'b0);
            if (rx_frame_valid && pulse_word < 0) pulse_word = w + 1;
        end
        send(term_word(0), 8'hFF, 1'b0);
        send(IDLE_W, 8'hFF, 1'b0);
        chk("ovf_pulses", pulses, 1);
        chk("ovf_word", pulse_word, 190);
        chk("ovf_len", last_len, 16'd1519);
        chk("ovf_good", last_good, 0);
        chk_cnt("ovf", 5, 3, 2, 0);
        send_frame(32'd4, 8, 0, 1'b0);
        chk("post_ovf_good", last_good, 1);
        chk_cnt("post_ovf", 6, 3, 2, 0);

        // Clear coinciding with a good frame's terminate word.
        pulses = 0;
        send_frame(32'd100, 8, 0, 1'b1);
        chk("clrc_pulses", pulses, 0);
        chk_cnt("clrc", 0, 0, 0, 0);
        send_frame(32'd7, 8, 0, 1'b0);
        send_frame(32'd8, 8, 0, 1'b0);
        chk_cnt("clrc_seq", 2, 0, 0, 0);
        send_frame(32'd50, 8, 0, 1'b0);
        chk_cnt("clrc_seqerr", 3, 0, 0, 1);

        // Reset in the middle of a frame.
        send(START_W, 8'h01, 1'b0);
        for (int w = 0; w < 4; w++) send(data_word(w, 32'd77), 8'h00, 1'b0);
        @(negedge clk_156);
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rx_frame_valid, 0);
        chk_cnt("mid_rst", 0, 0, 0, 0);
        @(negedge clk_156);
        sys_rst_n = 1'b1;
        pulses = 0;
        for (int w = 4; w < 8; w++) send(data_word(w, 32'd77), 8'h00, 1'b0);
        send(term_word(0), 8'hFF, 1'b0);
        send(IDLE_W, 8'hFF, 1'b0);
        chk("mid_rst_discard", pulses, 0);
        send_frame(32'd77, 8, 0, 1'b0);
        chk("resume_pulses", pulses, 1);
        chk("resume_good", last_good, 1);
        chk("resume_len", last_len, 16'd64);
        chk_cnt("resume", 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
